// File: rtl/tdp_ram_be_if.sv
`default_nettype none
// ============================================================================
// Module : tdp_ram_be_if
// Brief  : One access port of the byte-enabled true dual-port RAM.
// Rev    : 1.0
// ============================================================================
interface tdp_ram_be_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 32
) ();
  localparam int BE_SIZE = DATA_SIZE / 8;

  logic                 en;
  logic [BE_SIZE-1:0]   we;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] din;
  logic [DATA_SIZE-1:0] dout;
  logic                 valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface
`default_nettype wire

// File: rtl/tdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module : tdp_ram_be
// Brief  : True dual-port RAM, byte enables, RDW modes, lane arbitration, clear.
// Rev    : 1.0
// ============================================================================
module tdp_ram_be #(
  parameter int ADDR_SIZE      = 8,
  parameter int DATA_SIZE      = 32,
  parameter int RDW_MODE       = 0,
  parameter int COLL_PRIO      = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst,
  tdp_ram_be_if.slave        port_a_io,
  tdp_ram_be_if.slave        port_b_io,
  output logic               collision_o,
  output logic               busy_o
);
  localparam int BE_SIZE  = DATA_SIZE / 8;
  localparam int RAM_SIZE = 1 << ADDR_SIZE;
  localparam bit PRIO_B   = (COLL_PRIO != 0);
  localparam bit DO_CLEAR = (CLEAR_ON_RESET != 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                 state_q;
  logic [ADDR_SIZE-1:0]   clr_addr_q;
  logic [DATA_SIZE-1:0]   mem_q [RAM_SIZE];

  logic                   w_busy;
  logic                   w_acc_a, w_acc_b;
  logic [BE_SIZE-1:0]     w_we_a, w_we_b;
  logic                   w_wr_a, w_wr_b;
  logic                   w_same;
  logic                   w_coll;
  logic [DATA_SIZE-1:0]   w_old_a, w_old_b;
  logic [DATA_SIZE-1:0]   w_merge_a, w_merge_b;

  logic [DATA_SIZE-1:0]   dout_a_q, dout_b_q;
  logic                   valid_a_q, valid_b_q, coll_q;

  // Busy already shows in the reset cycle so masters see it before the sweep.
  assign w_busy  = (state_q == ST_CLEAR) || (rst && DO_CLEAR);
  assign w_acc_a = port_a_io.en && !w_busy && !rst;
  assign w_acc_b = port_b_io.en && !w_busy && !rst;
  assign w_we_a  = w_acc_a ? port_a_io.we : '0;
  assign w_we_b  = w_acc_b ? port_b_io.we : '0;
  assign w_wr_a  = |w_we_a;
  assign w_wr_b  = |w_we_b;
  assign w_same  = w_acc_a && w_acc_b && (port_a_io.addr == port_b_io.addr);
  assign w_coll  = w_same && (w_wr_a || w_wr_b);
  assign w_old_a = mem_q[port_a_io.addr];
  assign w_old_b = mem_q[port_b_io.addr];
  assign busy_o  = w_busy;

  // On a shared address both merges resolve to the same arbitrated word.
  for (genvar l = 0; l < BE_SIZE; l++) begin : g_lane
    logic w_a_gets_a, w_a_gets_b, w_b_gets_a, w_b_gets_b;

    assign w_a_gets_b = w_same && w_we_b[l] && (!w_we_a[l] || PRIO_B);
    assign w_a_gets_a = w_we_a[l] && !(w_same && w_we_b[l] && PRIO_B);
    assign w_b_gets_a = w_same && w_we_a[l] && (!w_we_b[l] || !PRIO_B);
    assign w_b_gets_b = w_we_b[l] && !(w_same && w_we_a[l] && !PRIO_B);

    assign w_merge_a[8*l +: 8] = w_a_gets_b ? port_b_io.din[8*l +: 8] :
                                 w_a_gets_a ? port_a_io.din[8*l +: 8] :
                                              w_old_a[8*l +: 8];
    assign w_merge_b[8*l +: 8] = w_b_gets_a ? port_a_io.din[8*l +: 8] :
                                 w_b_gets_b ? port_b_io.din[8*l +: 8] :
                                              w_old_b[8*l +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DO_CLEAR ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
      if (&clr_addr_q) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Array has no reset; only the sweep or a port write changes it.
  always_ff @(posedge clk) begin
    if ((state_q == ST_CLEAR) && !rst) begin
      mem_q[clr_addr_q] <= '0;
    end
    if (w_wr_a) begin
      mem_q[port_a_io.addr] <= w_merge_a;
    end
    if (w_wr_b) begin
      mem_q[port_b_io.addr] <= w_merge_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a_q  <= '0;
      dout_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= w_coll;
      if (w_acc_a) begin
        if (!w_wr_a || RDW_MODE == 0) begin
          dout_a_q  <= w_old_a;
          valid_a_q <= 1'b1;
        end else if (RDW_MODE == 1) begin
          dout_a_q  <= w_merge_a;
          valid_a_q <= 1'b1;
        end
      end
      if (w_acc_b) begin
        if (!w_wr_b || RDW_MODE == 0) begin
          dout_b_q  <= w_old_b;
          valid_b_q <= 1'b1;
        end else if (RDW_MODE == 1) begin
          dout_b_q  <= w_merge_b;
          valid_b_q <= 1'b1;
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_SIZE-1:0] dout_a_p_q, dout_b_p_q;
    logic                 valid_a_p_q, valid_b_p_q, coll_p_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_a_p_q  <= '0;
        dout_b_p_q  <= '0;
        valid_a_p_q <= 1'b0;
        valid_b_p_q <= 1'b0;
        coll_p_q    <= 1'b0;
      end else begin
        valid_a_p_q <= valid_a_q;
        valid_b_p_q <= valid_b_q;
        coll_p_q    <= coll_q;
        if (valid_a_q) dout_a_p_q <= dout_a_q;
        if (valid_b_q) dout_b_p_q <= dout_b_q;
      end
    end

    assign port_a_io.dout  = dout_a_p_q;
    assign port_b_io.dout  = dout_b_p_q;
    assign port_a_io.valid = valid_a_p_q;
    assign port_b_io.valid = valid_b_p_q;
    assign collision_o     = coll_p_q;
  end else begin : g_out_direct
    assign port_a_io.dout  = dout_a_q;
    assign port_b_io.dout  = dout_b_q;
    assign port_a_io.valid = valid_a_q;
    assign port_b_io.valid = valid_b_q;
    assign collision_o     = coll_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module : tb_tdp_ram_be
// Brief  : Directed bench driving three configurations of tdp_ram_be in lockstep.
// Rev    : 1.0
// ============================================================================
module tb_tdp_ram_be;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  we_a = '0, we_b = '0, addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic        coll0, coll1, coll2, busy0, busy1, busy2;
  int          total = 0;
  int          bad = 0;
  int          n;

  always #5 clk = ~clk;

  tdp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) a0 ();
  tdp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) b0 ();
  tdp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) a1 ();
  tdp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) b1 ();
  tdp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) a2 ();
  tdp_ram_be_if #(.ADDR_SIZE(4), .DATA_SIZE(32)) b2 ();

  assign a0.en = en_a; assign a0.we = we_a; assign a0.addr = addr_a; assign a0.din = din_a;
  assign b0.en = en_b; assign b0.we = we_b; assign b0.addr = addr_b; assign b0.din = din_b;
  assign a1.en = en_a; assign a1.we = we_a; assign a1.addr = addr_a; assign a1.din = din_a;
  assign b1.en = en_b; assign b1.we = we_b; assign b1.addr = addr_b; assign b1.din = din_b;
  assign a2.en = en_a; assign a2.we = we_a; assign a2.addr = addr_a; assign a2.din = din_a;
  assign b2.en = en_b; assign b2.we = we_b; assign b2.addr = addr_b; assign b2.din = din_b;

  // u0: read-first, A priority, latency 1, clear.
  tdp_ram_be #(.ADDR_SIZE(4), .DATA_SIZE(32), .RDW_MODE(0), .COLL_PRIO(0),
               .OUT_REG(0), .CLEAR_ON_RESET(1))
    u0 (.clk(clk), .rst(rst), .port_a_io(a0), .port_b_io(b0),
        .collision_o(coll0), .busy_o(busy0));
  // u1: write-first, B priority, latency 2, clear.
  tdp_ram_be #(.ADDR_SIZE(4), .DATA_SIZE(32), .RDW_MODE(1), .COLL_PRIO(1),
               .OUT_REG(1), .CLEAR_ON_RESET(1))
    u1 (.clk(clk), .rst(rst), .port_a_io(a1), .port_b_io(b1),
        .collision_o(coll1), .busy_o(busy1));
  // u2: no-change, A priority, latency 1, no clear.
  tdp_ram_be #(.ADDR_SIZE(4), .DATA_SIZE(32), .RDW_MODE(2), .COLL_PRIO(0),
               .OUT_REG(0), .CLEAR_ON_RESET(0))
    u2 (.clk(clk), .rst(rst), .port_a_io(a2), .port_b_io(b2),
        .collision_o(coll2), .busy_o(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                     input logic [31:0] da, input logic eb, input logic [3:0] wb,
                     input logic [3:0] ab, input logic [31:0] db);
    @(negedge clk);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy0", {31'b0, busy0}, 32'h1);
    chk("rst_busy2", {31'b0, busy2}, 32'h0);
    chk("rst_dout_a0", a0.dout, 32'h0);
    chk("rst_valid_a0", {31'b0, a0.valid}, 32'h0);
    chk("rst_coll0", {31'b0, coll0}, 32'h0);
    rst = 1'b0;
    chk("busy_after_rst", {31'b0, busy0}, 32'h1);
    n = 0;
    while (busy0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_len", n, 32'd16);
    chk("busy1_done", {31'b0, busy1}, 32'h0);
    chk("busy2_never", {31'b0, busy2}, 32'h0);

    // Cleared array reads back zero on both ports
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 4'h0, i[3:0], 32'h0, 1'b1, 4'h0, ~i[3:0], 32'h0);
      idle();
      chk("clr_rd_a", a0.dout, 32'h0);
      chk("clr_rd_a_valid", {31'b0, a0.valid}, 32'h1);
      chk("clr_rd_b", b0.dout, 32'h0);
    end

    // Mid-sweep reset restarts the sweep; accesses while busy are dropped
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        en_a = 1'b1; we_a = 4'hF; addr_a = 4'h0; din_a = 32'hFFFF_FFFF;
        en_b = 1'b1; we_b = 4'h0; addr_b = 4'h0;
      end else begin
        en_a = 1'b0; we_a = 4'h0; en_b = 1'b0;
      end
      if (n == 6) begin
        chk("busy_valid_a", {31'b0, a0.valid}, 32'h0);
        chk("busy_valid_b", {31'b0, b0.valid}, 32'h0);
        chk("busy_coll", {31'b0, coll0}, 32'h0);
      end
    end
    chk("restart_sweep_len", n, 32'd16);
    cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("busy_wr_dropped", a0.dout, 32'h0);
    chk("busy_wr_dropped_v", {31'b0, a0.valid}, 32'h1);

    // Byte-lane write and read latency
    cyc(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0);
    cyc(1'b1, 4'h2, 4'd5, 32'hAABB_CCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    cyc(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("lane_rd_u0", a0.dout, 32'h1122_CC44);
    chk("lane_rd_u0_v", {31'b0, a0.valid}, 32'h1);
    chk("lane_rd_u2", a2.dout, 32'h1122_CC44);
    chk("lat2_not_yet", {31'b0, a1.valid}, 32'h0);
    idle();
    chk("lane_rd_u1", a1.dout, 32'h1122_CC44);
    chk("lane_rd_u1_v", {31'b0, a1.valid}, 32'h1);

    // Read-during-write modes
    cyc(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("rdw0_dout", a0.dout, 32'h0);
    chk("rdw0_valid", {31'b0, a0.valid}, 32'h1);
    chk("rdw2_hold", a2.dout, 32'h1122_CC44);
    chk("rdw2_valid", {31'b0, a2.valid}, 32'h0);
    idle();
    chk("rdw1_dout", a1.dout, 32'hDEAD_BEEF);
    chk("rdw1_valid", {31'b0, a1.valid}, 32'h1);

    // Both ports write the same word
    cyc(1'b1, 4'b0011, 4'd7, 32'h1111_1111, 1'b1, 4'b0110, 4'd7, 32'h2222_2222);
    idle();
    chk("ww_coll0", {31'b0, coll0}, 32'h1);
    chk("ww_old_a0", a0.dout, 32'h0);
    chk("ww_old_b0", b0.dout, 32'h0);
    idle();
    chk("ww_coll0_pulse", {31'b0, coll0}, 32'h0);
    chk("ww_coll1", {31'b0, coll1}, 32'h1);
    chk("ww_wf_a1", a1.dout, 32'h0022_2211);
    chk("ww_wf_b1", b1.dout, 32'h0022_2211);
    cyc(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
    idle();
    chk("ww_store_u0", a0.dout, 32'h0022_1111);
    chk("rr_no_coll", {31'b0, coll0}, 32'h0);
    idle();
    chk("ww_store_u1", a1.dout, 32'h0022_2211);
    chk("ww_coll1_pulse", {31'b0, coll1}, 32'h0);

    // Cross-port write/read on one address
    cyc(1'b1, 4'hF, 4'd9, 32'h55, 1'b1, 4'h0, 4'd9, 32'h0);
    cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
    chk("xr_old_b0", b0.dout, 32'h0);
    chk("xr_valid_b0", {31'b0, b0.valid}, 32'h1);
    chk("xr_coll0", {31'b0, coll0}, 32'h1);
    idle();
    chk("xr_new_b0", b0.dout, 32'h55);
    chk("xr_coll0_clr", {31'b0, coll0}, 32'h0);
    chk("xr_old_b1", b1.dout, 32'h0);
    chk("xr_coll1", {31'b0, coll1}, 32'h1);
    idle();
    chk("xr_new_b1", b1.dout, 32'h55);
    chk("xr_coll1_clr", {31'b0, coll1}, 32'h0);

    // Independent writes at different addresses
    cyc(1'b1, 4'hF, 4'd10, 32'hAAAA_0000, 1'b1, 4'hF, 4'd11, 32'h0000_BBBB);
    idle();
    chk("diff_no_coll", {31'b0, coll0}, 32'h0);
    cyc(1'b1, 4'h0, 4'd11, 32'h0, 1'b1, 4'h0, 4'd10, 32'h0);
    idle();
    chk("diff_rd_a", a0.dout, 32'h0000_BBBB);
    chk("diff_rd_b", b0.dout, 32'hAAAA_0000);

    // Disabled port holds its last read
    cyc(1'b1, 4'hF, 4'd12, 32'h1234, 1'b0, 4'h0, 4'h0, 32'h0);
    cyc(1'b1, 4'h0, 4'd12, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("hold_rd", a0.dout, 32'h1234);
    chk("hold_rd_v", {31'b0, a0.valid}, 32'h1);
    idle();
    chk("hold_dout", a0.dout, 32'h1234);
    chk("hold_valid", {31'b0, a0.valid}, 32'h0);
    chk("hold_rd_u1", a1.dout, 32'h1234);
    idle();
    chk("hold_dout_u1", a1.dout, 32'h1234);
    chk("hold_valid_u1", {31'b0, a1.valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
